// File: rtl/deserializer_unit_cell_16.sv
// Serial-to-parallel deserializer with sync-word framing.
// Hunts for SYNC_WORD bit by bit, then emits FRAME_WORDS data words per frame
// and checks the sync word at every frame boundary. MISS_LIMIT consecutive bad
// sync words drop lock; a single miss is flywheeled with framing retained.
module deserializer_unit_cell_16 #(
    parameter logic [15:0] SYNC_WORD   = 16'hA5C3,
    parameter int          FRAME_WORDS = 4,
    parameter int          MISS_LIMIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        serial_in,
    output logic [15:0] par_out,
    output logic        par_valid,
    output logic        locked,
    output logic        sync_err,
    output logic [7:0]  err_cnt
);

    localparam logic [7:0] LAST_WORD = 8'(FRAME_WORDS - 1);
    localparam logic [4:0] MISS_LIM  = 5'(MISS_LIMIT);

    typedef enum logic [1:0] {HUNT, DATA, CHECK} state_t;

    state_t      state, state_nxt;
    logic [15:0] sr;
    logic [15:0] nxt_word;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  word_cnt, word_cnt_nxt;
    logic [3:0]  miss_cnt, miss_cnt_nxt;
    logic        boundary;
    logic        sync_hit;
    logic        load_word;
    logic        sync_miss;

    // Shift register contents after this cycle's bit lands (LSB first on line).
    assign nxt_word = {serial_in, sr[15:1]};
    assign boundary = (bit_cnt == 4'd15);
    assign sync_hit = (nxt_word == SYNC_WORD);

    // Next-state and counter decode; CHECK only compares at its word boundary,
    // so a failed check word can never re-match in HUNT on the same cycle.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt + 4'd1;
        word_cnt_nxt = word_cnt;
        miss_cnt_nxt = miss_cnt;
        load_word    = 1'b0;
        sync_miss    = 1'b0;
        case (state)
            HUNT: begin
                bit_cnt_nxt = 4'd0;
                if (sync_hit) begin
                    state_nxt    = DATA;
                    word_cnt_nxt = 8'd0;
                    miss_cnt_nxt = 4'd0;
                end
            end
            DATA: begin
                if (boundary) begin
                    load_word = 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        state_nxt    = CHECK;
                        word_cnt_nxt = 8'd0;
                    end else begin
                        word_cnt_nxt = word_cnt + 8'd1;
                    end
                end
            end
            CHECK: begin
                if (boundary) begin
                    if (sync_hit) begin
                        miss_cnt_nxt = 4'd0;
                        state_nxt    = DATA;
                    end else begin
                        sync_miss    = 1'b1;
                        miss_cnt_nxt = miss_cnt + 4'd1;
                        if (({1'b0, miss_cnt} + 5'd1) == MISS_LIM)
                            state_nxt = HUNT;
                        else
                            state_nxt = DATA;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // All registered state and outputs; reset wins over every update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            sr        <= 16'h0000;
            bit_cnt   <= 4'd0;
            word_cnt  <= 8'd0;
            miss_cnt  <= 4'd0;
            par_out   <= 16'h0000;
            par_valid <= 1'b0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            state     <= state_nxt;
            sr        <= nxt_word;
            bit_cnt   <= bit_cnt_nxt;
            word_cnt  <= word_cnt_nxt;
            miss_cnt  <= miss_cnt_nxt;
            par_valid <= load_word;
            sync_err  <= sync_miss;
            locked    <= (state_nxt != HUNT);
            if (load_word)
                par_out <= nxt_word;
            if (sync_miss && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: doc/deserializer_unit_cell_16.md
DESERIALIZER_UNIT_CELL_16 -- requirements
Module: deserializer_unit_cell_16

Interface
REQ-001 Parameter: SYNC_WORD, default 16'hA5C3, frame-alignment word (bit 0 on the line first).
REQ-002 Parameter: FRAME_WORDS, default 4, data words between sync words (legal 1..255).
REQ-003 Parameter: MISS_LIMIT, default 2, consecutive sync misses that drop lock (legal 1..15).
REQ-004 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 SERIAL_IN  input  1  serial data, one bit per CLK, LSB of each word first.
REQ-007 PAR_OUT  output  16  last recovered data word, registered.
REQ-008 PAR_VALID  output  1  one-cycle pulse: PAR_OUT updated this cycle.
REQ-009 LOCKED  output  1  high whenever the FSM is not in HUNT.
REQ-010 SYNC_ERR  output  1  one-cycle pulse on a failed sync-word check.
REQ-011 ERR_CNT  output  8  saturating count of sync-check failures since reset.

Function
REQ-012 Shift register SR[15:0] SHALL update every cycle as SR <= {SERIAL_IN, SR[15:1]}, in all states; NEXT denotes {SERIAL_IN, SR[15:1]}.
REQ-013 FSM states SHALL be HUNT, DATA, CHECK; reset state HUNT.
REQ-014 HUNT: each cycle compare NEXT to SYNC_WORD; on match -> DATA with BIT_CNT=0, WORD_CNT=0, MISS_CNT=0; no match -> stay.
REQ-015 DATA/CHECK: 4-bit BIT_CNT SHALL increment each cycle, wrapping 15->0; the cycle with BIT_CNT==15 is the word boundary.
REQ-016 DATA word boundary: PAR_OUT <= NEXT, PAR_VALID=1 for the following cycle, WORD_CNT increments; if WORD_CNT was FRAME_WORDS-1 -> CHECK with WORD_CNT=0, else stay in DATA.
REQ-017 Latency: PAR_VALID and the new PAR_OUT SHALL be visible in the cycle immediately after the 16th bit of a word is sampled.
REQ-018 PAR_OUT SHALL hold its value between PAR_VALID pulses; PAR_VALID SHALL never assert in HUNT or for the sync word.
REQ-019 CHECK word boundary, NEXT==SYNC_WORD: MISS_CNT <= 0, -> DATA.
REQ-020 CHECK word boundary, mismatch: SYNC_ERR pulses one cycle, ERR_CNT increments saturating at 255, MISS_CNT increments; if MISS_CNT+1 == MISS_LIMIT -> HUNT (LOCKED falls next cycle), else -> DATA (flywheel, word framing retained).
REQ-021 On re-entry to HUNT, matching SHALL consider NEXT in the same cycle as the transition only from the following cycle (no match on the failed check word itself).
REQ-022 A SYNC_WORD pattern appearing inside DATA words SHALL be ignored (no re-alignment while locked).
REQ-023 LOCKED SHALL be a registered decode of state (high in DATA and CHECK).

Reset
REQ-024 With RESET high at a CLK edge: state=HUNT, SR=0, BIT_CNT=WORD_CNT=MISS_CNT=0, PAR_OUT=16'h0000, PAR_VALID=0, LOCKED=0, SYNC_ERR=0, ERR_CNT=0.
REQ-025 RESET asserted mid-word or mid-frame SHALL discard partial data with no PAR_VALID pulse; RESET has priority over all other updates.
REQ-026 After RESET deasserts, the first sampled bit SHALL be the first bit considered for sync detection.

Verification
REQ-027 Lock: after reset, send 16'hA5C3 then 16'h1234 LSB-first -> LOCKED=1 one cycle after sync's 16th bit; PAR_OUT=16'h1234 with single PAR_VALID pulse 16 cycles later.
REQ-028 Frame: sync, 4 words (0001,0002,0003,0004), sync, 4 words -> 8 PAR_VALID pulses in order, SYNC_ERR never asserted, ERR_CNT=0.
REQ-029 Flywheel: one corrupted sync (16'hA5C2) -> SYNC_ERR single pulse, ERR_CNT=1, LOCKED stays 1, next 4 words still delivered.
REQ-030 Loss of lock: two consecutive bad sync words -> ERR_CNT=2, LOCKED=0, no PAR_VALID until a new 16'hA5C3 is received, then relock.
REQ-031 Misaligned start: 5 random bits then sync and data -> correct alignment; embedded 16'hA5C3 data word while locked -> delivered as data, no realignment.
REQ-032 Reset mid-word: assert RESET after 7 bits of a data word -> all outputs at reset values, no PAR_VALID; 300 bad syncs (with relocks) -> ERR_CNT saturates at 255.
